fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request port. It replaces free-running PC increment with a handshaked fetch: one outstanding request, stall back-pressure from decode, and branch/jump redirect with wrong-path squash. It sits between the branch-resolution logic, which supplies the redirect target, and the instruction memory.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Clears the byte-offset bits of a fetch address.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    TRAP
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight, squashes wrong-path data.
// Optional FETCH_ALIGN_CHECK_EN traps on misaligned redirect targets instead of silently aligning them.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign_trap
);

  // Handshakes: a request transfers on a cycle with imem_req && imem_ready; the
  // response is the single imem_rvalid pulse that follows; decode takes the
  // instruction on a cycle with instr_valid && !stall. redirect_valid wins over all.

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            kill_q, kill_d;

  logic [XLEN-1:0] tgt;
  logic            tgt_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt     = redirect_target;
  assign tgt_bad = |redirect_target[1:0];
`else
  assign tgt     = redirect_target & ALIGN_MASK;
  assign tgt_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (tgt_bad) begin
            state_d = TRAP;
          end else if (imem_ready) begin
            // Memory already took the old address; its answer must be dropped.
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (tgt_bad) begin
            kill_d  = 1'b0;
            state_d = TRAP;
          end else if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q) begin
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = OUT;
          end
        end
      end

      OUT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = tgt_bad ? TRAP : REQ;
        end else if (!stall) begin
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
          state_d = REQ;
        end
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == OUT) && !redirect_valid;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_trap = (state_q == TRAP);
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run against an architectural PC model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_trap;

  int n_checks = 0;
  int n_errors = 0;
  int cycle_no = 0;

  logic [31:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .misalign_trap   (misalign_trap)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory contents / driver helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    imem_ready      = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL reset_req: req=%0b addr=%08h, want req=0 addr=%08h", imem_req, imem_addr, RESET_PC);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_instr: valid=%0b instr=%08h pc=%08h, want 0/0/0", instr_valid, instr, instr_pc);
    end
    n_checks++;
    if (misalign_trap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_trap: got %0b want 0", misalign_trap);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_req: got %0b want 0 in first cycle after release", imem_req);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_errors++;
      $display("FAIL first_req: req=%0b addr=%08h, want 1/%08h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_fetch_loop();
    int t_req[3];
    exp_q = {32'h0, 32'h4, 32'h8};
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      logic [31:0] e;
      a = 32'(k * 4);
      imem_ready = 1'b1;
      #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_errors++;
        $display("FAIL loop_req: req=%0b addr=%08h, want 1/%08h", imem_req, imem_addr, a);
      end
      t_req[k] = cycle_no;
      cyc();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL loop_wait: req=%0b valid=%0b, want 0/0", imem_req, instr_valid);
      end
      cyc();
      imem_rvalid = 1'b0;
      stall       = 1'b0;
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== e || instr !== mem_word(e)) begin
        n_errors++;
        $display("FAIL loop_out: valid=%0b pc=%08h instr=%08h, want 1/%08h/%08h",
                 instr_valid, instr_pc, instr, e, mem_word(e));
      end
      cyc();
    end
    n_checks++;
    if (t_req[1] - t_req[0] != 3 || t_req[2] - t_req[1] != 3) begin
      n_errors++;
      $display("FAIL loop_period: gaps %0d,%0d cycles, want 3,3", t_req[1] - t_req[0], t_req[2] - t_req[1]);
    end
  endtask

  task automatic test_stall();
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_errors++;
      $display("FAIL stall_req: req=%0b addr=%08h, want 1/0000000c", imem_req, imem_addr);
    end
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'hC);
    cyc();
    imem_rvalid = 1'b0;
    stall       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== mem_word(32'hC) || instr_pc !== 32'hC || imem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b instr=%08h pc=%08h req=%0b, want 1/%08h/0000000c/0",
                 i, instr_valid, instr, instr_pc, imem_req, mem_word(32'hC));
      end
      cyc();
    end
    stall = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: valid=%0b want 1", instr_valid);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++;
      $display("FAIL stall_next: req=%0b addr=%08h, want 1/00000010", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1'b1;
    #1;
    cyc();
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL rdw_wait: req=%0b want 0", imem_req);
    end
    cyc();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = mem_word(32'h10);
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rdw_resp: req=%0b valid=%0b, want 0/0", imem_req, instr_valid);
    end
    cyc();
    imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL rdw_target: valid=%0b req=%0b addr=%08h, want 0/1/00000100", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_accept();
    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h100);
    cyc();
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      n_errors++;
      $display("FAIL rda_first: valid=%0b pc=%08h instr=%08h, want 1/00000100/%08h",
               instr_valid, instr_pc, instr, mem_word(32'h100));
    end
    cyc();
    imem_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      n_errors++;
      $display("FAIL rda_req: req=%0b addr=%08h, want 1/00000104", imem_req, imem_addr);
    end
    cyc();
    imem_ready     = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = mem_word(32'h104);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_errors++;
      $display("FAIL rda_target: valid=%0b req=%0b addr=%08h, want 0/1/00000200", instr_valid, imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h200);
    cyc();
    imem_rvalid = 1'b0;
    stall       = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin
      n_errors++;
      $display("FAIL rda_fetch: valid=%0b pc=%08h instr=%08h, want 1/00000200/%08h",
               instr_valid, instr_pc, instr, mem_word(32'h200));
    end
  endtask

  task automatic test_redirect_out_stall();
    cyc();
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rdo_squash: valid=%0b want 0 in redirect cycle", instr_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_errors++;
      $display("FAIL rdo_target: req=%0b addr=%08h, want 1/00000300", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_redirect_req: req=%0b addr=%08h, want 1/fffffffc", imem_req, imem_addr);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_addr_stable: req=%0b addr=%08h, want 1/fffffffc", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'hFFFF_FFFC);
    cyc();
    imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_out: valid=%0b pc=%08h, want 1/fffffffc", instr_valid, instr_pc);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_next: req=%0b addr=%08h, want 1/00000000", imem_req, imem_addr);
    end
    // A stray response while requesting must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_rvalid: req=%0b addr=%08h valid=%0b, want 1/00000000/0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_misalign();
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    cyc();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      imem_ready  = ($urandom_range(0, 1) == 1);
      imem_rvalid = ($urandom_range(0, 1) == 1);
      stall       = ($urandom_range(0, 1) == 1);
      #1;
      n_checks++;
      if (misalign_trap !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h102) begin
        n_errors++;
        $display("FAIL trap_hold[%0d]: trap=%0b req=%0b valid=%0b addr=%08h, want 1/0/0/00000102",
                 i, misalign_trap, imem_req, instr_valid, imem_addr);
      end
      cyc();
    end
    drive_idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if (misalign_trap !== 1'b0 || imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL trap_clear: trap=%0b req=%0b, want 0/0 after reset", misalign_trap, imem_req);
    end
`else
    #1;
    n_checks++;
    if (misalign_trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL align_force: trap=%0b req=%0b addr=%08h, want 0/1/00000100", misalign_trap, imem_req, imem_addr);
    end
`endif
  endtask

  // Randomized traffic; the model only tracks the architectural next PC.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pending;
    int          wait_cnt;
    int          consumed;
    rst = 1'b0;
    drive_idle();
    repeat (2) cyc();
    rst       = 1'b1;
    exp_pc    = RESET_PC;
    pending   = 1'b0;
    pend_addr = '0;
    wait_cnt  = 0;
    consumed  = 0;
    for (int c = 0; c < 2000; c++) begin
      logic rv_real;
      rv_real     = pending && (wait_cnt == 0);
      imem_rvalid = rv_real;
      imem_rdata  = rv_real ? mem_word(pend_addr) : $urandom;
      if (!pending && $urandom_range(0, 15) == 0) imem_rvalid = 1'b1;
      imem_ready      = ($urandom_range(0, 1) == 1);
      stall           = ($urandom_range(0, 2) == 0);
      redirect_valid  = (c > 2) && ($urandom_range(0, 11) == 0);
      redirect_target = $urandom & 32'hFFFF_FFFC;
      #1;
      if (imem_req && imem_ready && !redirect_valid) begin
        n_checks++;
        if (imem_addr !== exp_pc) begin
          n_errors++;
          $display("FAIL rnd_req_addr c=%0d: addr=%08h want %08h", c, imem_addr, exp_pc);
        end
      end
      if (pending && imem_req) begin
        n_checks++;
        n_errors++;
        $display("FAIL rnd_outstanding c=%0d: req=1 while a response is owed, want 0", c);
      end
      if (redirect_valid && instr_valid) begin
        n_checks++;
        n_errors++;
        $display("FAIL rnd_squash c=%0d: instr_valid=1 during redirect, want 0", c);
      end
      if (instr_valid && !stall) begin
        n_checks++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          n_errors++;
          $display("FAIL rnd_consume c=%0d: pc=%08h instr=%08h, want %08h/%08h",
                   c, instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      if (redirect_valid) exp_pc = redirect_target;
      if (rv_real) pending = 1'b0;
      else if (pending) wait_cnt = wait_cnt - 1;
      if (imem_req && imem_ready) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        wait_cnt  = $urandom_range(0, 2);
      end
      cyc();
    end
    drive_idle();
    n_checks++;
    if (consumed < 100) begin
      n_errors++;
      $display("FAIL rnd_progress: %0d instructions consumed, want at least 100", consumed);
    end
    n_checks++;
    if (misalign_trap !== 1'b0) begin
      n_errors++;
      $display("FAIL rnd_trap: trap=%0b want 0 with aligned targets", misalign_trap);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch_loop();
    test_stall();
    test_redirect_wait();
    test_redirect_accept();
    test_redirect_out_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
